// File: rtl/char_roi_sequencer_pkg.sv
// Shared types and helpers for the character ROI sequencer.
package char_seg_pkg;

    localparam int CHAR_NUM = 7;
    localparam int COORD_W  = 10;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_ISSUE,
        S_DONE
    } seq_state_e;

    // Seven packed coordinates, character k at bits [10k+9:10k].
    typedef logic [CHAR_NUM*COORD_W-1:0] bound_bus_t;

    // Pull character k's coordinate out of a packed bounds bus.
    function automatic logic [COORD_W-1:0] bus_slice(input bound_bus_t bus,
                                                     input logic [IDX_W-1:0] k);
        return bus[int'(k)*COORD_W +: COORD_W];
    endfunction

endpackage

// File: rtl/char_roi_sequencer_if.sv
// Character window handshake towards the recogniser.
interface char_roi_sequencer_if;
    import char_seg_pkg::*;

    logic               roi_valid;
    logic               roi_ready;
    logic [IDX_W-1:0]   roi_index;
    logic [COORD_W-1:0] roi_left;
    logic [COORD_W-1:0] roi_right;
    logic [COORD_W-1:0] roi_top;
    logic [COORD_W-1:0] roi_bottom;

    modport master (
        output roi_valid, roi_index, roi_left, roi_right, roi_top, roi_bottom,
        input  roi_ready
    );

    modport slave (
        input  roi_valid, roi_index, roi_left, roi_right, roi_top, roi_bottom,
        output roi_ready
    );

endinterface

// File: rtl/char_roi_sequencer_bound_check.sv
// Validity test for one character's column bounds.
module char_bound_check
    import char_seg_pkg::*;
#(
    parameter int IMG_HDISP  = 640,
    parameter int MIN_CHAR_W = 2,
    parameter int MAX_CHAR_W = 80
) (
    input  logic [COORD_W-1:0] left,
    input  logic [COORD_W-1:0] right,
    input  logic [COORD_W-1:0] prev_right,
    input  logic               first,
    output logic               ok
);

    // One extra bit so a reversed pair cannot wrap back into the legal range.
    localparam logic [COORD_W:0] MIN_W = (COORD_W+1)'(MIN_CHAR_W);
    localparam logic [COORD_W:0] MAX_W = (COORD_W+1)'(MAX_CHAR_W);
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(IMG_HDISP);

    logic [COORD_W:0] width;

    assign width = {1'b0, right} - {1'b0, left} + {{COORD_W{1'b0}}, 1'b1};

    // All bound rules must hold; the ordering rule is skipped for character 0.
    always_comb begin
        ok = (right >= left)
          && (width >= MIN_W)
          && (width <= MAX_W)
          && ({1'b0, right} < H_LIM)
          && (first || (left > prev_right));
    end

endmodule

// File: rtl/char_roi_sequencer.sv
// Per-frame sequencer: latches the plate row window, snapshots and validates
// the seven character column bounds, then offers them one by one downstream.
module char_roi_sequencer
    import char_seg_pkg::*;
#(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int SETTLE_CYC = 4,
    parameter int MIN_CHAR_W = 2,
    parameter int MAX_CHAR_W = 80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  plate_valid,
    input  logic [COORD_W-1:0]    plate_top,
    input  logic [COORD_W-1:0]    plate_bottom,
    input  bound_bus_t            char_left_bus,
    input  bound_bus_t            char_right_bus,
    output logic [COORD_W-1:0]    vertical_start,
    output logic [COORD_W-1:0]    vertical_end,
    char_roi_sequencer_if.master  roi,
    output logic [CHAR_NUM-1:0]   err_mask,
    output logic                  seg_error,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int                 CNT_W    = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(IMG_VDISP - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(CHAR_NUM - 1);

    seq_state_e          state, state_d;
    logic                vsync_r, fs, plate_ok, accept, settle_done;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    idx, idx_d, idx_prev;
    bound_bus_t          snap_l, snap_r;
    logic                chk_ok, err_any;
    logic [CHAR_NUM-1:0] err_mask_d;

    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [COORD_W-1:0]  left_q, left_d, right_q, right_d;
    logic                seg_err_d, done_d, overrun_d;

    assign fs          = per_frame_vsync & ~vsync_r;
    assign plate_ok    = plate_valid && (plate_top < plate_bottom) && (plate_bottom <= V_LAST);
    assign accept      = valid_q & roi.roi_ready;
    assign settle_done = (state == S_WAIT) && (cnt == CNT_LAST) && !fs;
    assign idx_prev    = (idx == '0) ? '0 : idx - 1'b1;
    // Bits 0..5 are already registered by the time character 6 is checked.
    assign err_any     = (|err_mask) | ~chk_ok;

    assign roi.roi_valid  = valid_q;
    assign roi.roi_index  = index_q;
    assign roi.roi_left   = left_q;
    assign roi.roi_right  = right_q;
    assign roi.roi_top    = vertical_start;
    assign roi.roi_bottom = vertical_end;

    char_bound_check #(
        .IMG_HDISP  (IMG_HDISP),
        .MIN_CHAR_W (MIN_CHAR_W),
        .MAX_CHAR_W (MAX_CHAR_W)
    ) u_bound_check (
        .left       (bus_slice(snap_l, idx)),
        .right      (bus_slice(snap_r, idx)),
        .prev_right (bus_slice(snap_r, idx_prev)),
        .first      (idx == '0),
        .ok         (chk_ok)
    );

    // Vsync edge detect and plate row window latch on every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r        <= 1'b0;
            vertical_start <= '0;
            vertical_end   <= V_LAST;
        end else begin
            vsync_r <= per_frame_vsync;
            if (fs && plate_ok) begin
                vertical_start <= plate_top;
                vertical_end   <= plate_bottom;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // FSM next state; a frame start always restarts the settle wait.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (fs) state_d = S_WAIT;
            S_WAIT:  if (fs) state_d = S_WAIT;
                     else if (cnt == CNT_LAST) state_d = S_CHECK;
            S_CHECK: if (fs) state_d = S_WAIT;
                     else if (idx == IDX_LAST) state_d = err_any ? S_IDLE : S_ISSUE;
            S_ISSUE: if (fs) state_d = S_WAIT;
                     else if (accept && idx == IDX_LAST) state_d = S_DONE;
            S_DONE:  state_d = fs ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: next values for counters, error mask and registered outputs.
    always_comb begin
        cnt_d      = (state == S_WAIT && !fs) ? cnt + 1'b1 : '0;
        idx_d      = '0;
        err_mask_d = err_mask;
        case (state)
            S_CHECK: idx_d = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            S_ISSUE: idx_d = accept ? idx + 1'b1 : idx;
            default: idx_d = '0;
        endcase
        if (settle_done)
            err_mask_d = '0;
        else if (state == S_CHECK && !chk_ok)
            err_mask_d = err_mask | (CHAR_NUM'(1) << idx);

        valid_d   = (state_d == S_ISSUE);
        index_d   = valid_d ? idx_d : '0;
        left_d    = valid_d ? bus_slice(snap_l, idx_d) : '0;
        right_d   = valid_d ? bus_slice(snap_r, idx_d) : '0;
        seg_err_d = (state == S_CHECK) && !fs && (idx == IDX_LAST) && err_any;
        done_d    = (state_d == S_DONE);
        overrun_d = fs && (state == S_WAIT || state == S_CHECK || state == S_ISSUE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            snap_l     <= '0;
            snap_r     <= '0;
            err_mask   <= '0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            seg_error  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            idx        <= idx_d;
            err_mask   <= err_mask_d;
            valid_q    <= valid_d;
            index_q    <= index_d;
            left_q     <= left_d;
            right_q    <= right_d;
            seg_error  <= seg_err_d;
            frame_done <= done_d;
            overrun    <= overrun_d;
            if (settle_done) begin
                snap_l <= char_left_bus;
                snap_r <= char_right_bus;
            end
        end
    end

endmodule

// File: tb/tb_char_roi_sequencer.sv
// Directed bench for char_roi_sequencer.
module tb_char_roi_sequencer;
    import char_seg_pkg::*;

    logic               clk, rst_n, per_frame_vsync, plate_valid;
    logic [COORD_W-1:0] plate_top, plate_bottom, vertical_start, vertical_end;
    bound_bus_t         lbus, rbus;
    logic [CHAR_NUM-1:0] err_mask;
    logic               seg_error, frame_done, overrun;

    char_roi_sequencer_if rif();

    char_roi_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .plate_valid     (plate_valid),
        .plate_top       (plate_top),
        .plate_bottom    (plate_bottom),
        .char_left_bus   (lbus),
        .char_right_bus  (rbus),
        .vertical_start  (vertical_start),
        .vertical_end    (vertical_end),
        .roi             (rif),
        .err_mask        (err_mask),
        .seg_error       (seg_error),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nom_l [7] = '{10, 40, 90, 120, 150, 180, 210};
    int nom_r [7] = '{30, 60, 110, 140, 170, 200, 230};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic set_char(input int k, input int l, input int r);
        lbus[k*COORD_W +: COORD_W] = l[COORD_W-1:0];
        rbus[k*COORD_W +: COORD_W] = r[COORD_W-1:0];
    endtask

    task automatic load_nominal();
        for (int k = 0; k < 7; k++) set_char(k, nom_l[k], nom_r[k]);
    endtask

    task automatic set_plate(input logic v, input int t, input int b);
        plate_valid  = v;
        plate_top    = t[COORD_W-1:0];
        plate_bottom = b[COORD_W-1:0];
    endtask

    // Raise vsync in cycle T; returns at the sample point of T+1.
    task automatic start_frame();
        @(negedge clk);
        per_frame_vsync = 1'b1;
        @(negedge clk);
        per_frame_vsync = 1'b0;
    endtask

    // Nominal frame with ready high; checks latch result and completion time.
    task automatic run_frame(input string tag, input int vs, input int ve);
        start_frame();
        chk({tag, "_vstart"}, vertical_start, vs);
        chk({tag, "_vend"}, vertical_end, ve);
        repeat (18) @(negedge clk);
        chk({tag, "_done_t19"}, frame_done, 1);
        @(negedge clk);
    endtask

    int exp_k, acc, dn, vcnt;

    initial begin
        rst_n = 1'b0; per_frame_vsync = 1'b0; rif.roi_ready = 1'b0;
        lbus = '0; rbus = '0;
        set_plate(1'b0, 0, 0);
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_vstart", vertical_start, 0);
        chk("rst_vend", vertical_end, 479);
        chk("rst_valid", rif.roi_valid, 0);
        chk("rst_err", err_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // nominal frame
        load_nominal();
        set_plate(1'b1, 100, 160);
        rif.roi_ready = 1'b1;
        start_frame();
        chk("nom_vstart", vertical_start, 100);
        chk("nom_vend", vertical_end, 160);
        repeat (10) @(negedge clk);
        chk("nom_valid_t11", rif.roi_valid, 0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("nom_valid", rif.roi_valid, 1);
            chk("nom_index", rif.roi_index, k);
            chk("nom_left", rif.roi_left, nom_l[k]);
            chk("nom_right", rif.roi_right, nom_r[k]);
            chk("nom_top", rif.roi_top, 100);
            chk("nom_bottom", rif.roi_bottom, 160);
        end
        @(negedge clk);
        chk("nom_done_t19", frame_done, 1);
        chk("nom_valid_t19", rif.roi_valid, 0);
        chk("nom_err", err_mask, 0);
        @(negedge clk);
        chk("nom_done_t20", frame_done, 0);

        // back-pressure: ready one cycle on, two off
        rif.roi_ready = 1'b0;
        start_frame();
        exp_k = 0; acc = 0; dn = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (rif.roi_valid) begin
                chk("bp_index", rif.roi_index, exp_k);
                chk("bp_left", rif.roi_left, nom_l[exp_k % 7]);
                chk("bp_right", rif.roi_right, nom_r[exp_k % 7]);
            end
            if (frame_done) dn++;
            rif.roi_ready = (c % 3 == 0);
            if (rif.roi_valid && rif.roi_ready) begin
                exp_k++; acc++;
            end
        end
        chk("bp_accepts", acc, 7);
        chk("bp_done_cnt", dn, 1);
        rif.roi_ready = 1'b1;

        // invalid characters 3 and 5
        load_nominal();
        set_char(3, 130, 125);
        set_char(5, 180, 269);
        set_char(6, 280, 300);
        start_frame();
        vcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (rif.roi_valid) vcnt++;
            if (c == 12) begin
                chk("inv_seg_t12", seg_error, 1);
                chk("inv_mask_t12", err_mask, 7'b0101000);
            end
            if (c == 13) chk("inv_seg_t13", seg_error, 0);
        end
        chk("inv_no_valid", vcnt, 0);
        chk("inv_mask_held", err_mask, 7'b0101000);

        // overlap: char 2 starts inside char 1
        load_nominal();
        set_char(2, 55, 110);
        start_frame();
        vcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (rif.roi_valid) vcnt++;
            if (c == 12) chk("ovl_seg_t12", seg_error, 1);
        end
        chk("ovl_mask", err_mask, 7'b0000100);
        chk("ovl_no_valid", vcnt, 0);

        // bad plates keep the old window; sequencing still completes
        load_nominal();
        set_plate(1'b0, 200, 300);
        run_frame("plate_invalid", 100, 160);
        set_plate(1'b1, 300, 300);
        run_frame("plate_equal", 100, 160);
        set_plate(1'b1, 200, 480);
        run_frame("plate_past_end", 100, 160);
        set_plate(1'b1, 200, 479);
        run_frame("plate_last_row", 200, 479);
        chk("plate_roi_bottom", rif.roi_bottom, 479);

        // abort during ISSUE at k=3
        set_plate(1'b1, 100, 160);
        start_frame();
        repeat (14) @(negedge clk);
        chk("abt_index_k3", rif.roi_index, 3);
        chk("abt_valid_k3", rif.roi_valid, 1);
        rif.roi_ready   = 1'b0;
        per_frame_vsync = 1'b1;
        set_plate(1'b1, 50, 90);
        @(negedge clk);
        per_frame_vsync = 1'b0;
        rif.roi_ready   = 1'b1;
        chk("abt_overrun", overrun, 1);
        chk("abt_valid_drop", rif.roi_valid, 0);
        chk("abt_vstart", vertical_start, 50);
        chk("abt_vend", vertical_end, 90);
        @(negedge clk);
        chk("abt_overrun_pulse", overrun, 0);
        repeat (10) @(negedge clk);
        chk("abt_restart_valid", rif.roi_valid, 1);
        chk("abt_restart_index", rif.roi_index, 0);
        chk("abt_restart_top", rif.roi_top, 50);
        @(negedge clk);
        chk("abt_restart_index1", rif.roi_index, 1);
        repeat (6) @(negedge clk);
        chk("abt_done", frame_done, 1);
        @(negedge clk);

        // reset asserted mid-ISSUE
        rif.roi_ready = 1'b0;
        start_frame();
        repeat (11) @(negedge clk);
        chk("rst2_pre_valid", rif.roi_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", rif.roi_valid, 0);
        chk("rst2_left", rif.roi_left, 0);
        chk("rst2_index", rif.roi_index, 0);
        chk("rst2_vstart", vertical_start, 0);
        chk("rst2_vend", vertical_end, 479);
        chk("rst2_err", err_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rif.roi_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst2_idle_valid", rif.roi_valid, 0);
        chk("rst2_idle_done", frame_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
